// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage: captures signed or unsigned operands,
// runs WIDTH add/shift steps while stalling the front end, then presents a 2*WIDTH product.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, mcand_reg;
    logic             neg_reg;

    logic             capture, finish, step;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_hi_next, acc_lo_next;
    logic [2*WIDTH-1:0] product, product_final;

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    assign mag_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // One shift-add step; the adder carry becomes the new MSB after the shift.
    assign sum         = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mcand_reg} : '0);
    assign acc_hi_next = sum[WIDTH:1];
    assign acc_lo_next = {sum[0], acc_lo_reg[WIDTH-1:1]};
    assign product       = {acc_hi_next, acc_lo_next};
    assign product_final = neg_reg ? -product : product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    capture    = 1'b1;
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy  = 1'b1;
                stall = !flush;
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count_reg == CW'(1)) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // start is still high for the retiring MUL, so it is not looked at here
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            mcand_reg  <= '0;
            neg_reg    <= 1'b0;
            result_lo  <= '0;
            result_hi  <= '0;
        end else if (capture) begin
            count_reg  <= CW'(WIDTH);
            acc_hi_reg <= '0;
            acc_lo_reg <= mag_b;
            mcand_reg  <= mag_a;
            neg_reg    <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (step) begin
            count_reg  <= count_reg - CW'(1);
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            if (finish) begin
                result_hi <= product_final[2*WIDTH-1:WIDTH];
                result_lo <= product_final[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: 32-bit and 8-bit instances, directed corner cases
// plus randomized operands checked against a plain-arithmetic product model.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, signed_op, flush;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result_lo, result_hi;

    logic        start8, signed8, flush8;
    logic [7:0]  a8, b8;
    logic        stall8, busy8, done8;
    logic [7:0]  lo8, hi8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .busy(busy),
        .done(done), .result_lo(result_lo), .result_hi(result_hi)
    );

    mul_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(signed8),
        .op_a(a8), .op_b(b8), .flush(flush8), .stall(stall8), .busy(busy8),
        .done(done8), .result_lo(lo8), .result_hi(hi8)
    );

    // Product modulo 2^(2W) of sign- or zero-extended operands equals the true product.
    function automatic logic [63:0] ref_mul32(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b,
                                             input logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'b0, a};
        eb = s ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    task automatic do_mul32(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input string name);
        logic [63:0] exp_p;
        exp_p = ref_mul32(a, b, s);
        @(posedge clk); #1;
        start = 1'b1; signed_op = s; op_a = a; op_b = b;
        for (int cyc = 0; cyc <= 33; cyc++) begin
            @(negedge clk);
            checks++;
            if (stall !== (cyc <= 32) || busy !== (cyc >= 1 && cyc <= 32) || done !== (cyc == 33)) begin
                failures++;
                $display("FAIL %s ctl cyc=%0d stall=%b busy=%b done=%b", name, cyc, stall, busy, done);
            end
            if (cyc == 33) begin
                checks++;
                if ({result_hi, result_lo} !== exp_p) begin
                    failures++;
                    $display("FAIL %s product got=%h exp=%h", name, {result_hi, result_lo}, exp_p);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after stall=%b busy=%b done=%b", name, stall, busy, done);
        end
        $display("mul32 %s a=%h b=%h s=%b -> %h%h", name, a, b, s, result_hi, result_lo);
    endtask

    task automatic do_mul8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input string name);
        logic [15:0] exp_p;
        exp_p = ref_mul8(a, b, s);
        @(posedge clk); #1;
        start8 = 1'b1; signed8 = s; a8 = a; b8 = b;
        for (int cyc = 0; cyc <= 9; cyc++) begin
            @(negedge clk);
            checks++;
            if (stall8 !== (cyc <= 8) || busy8 !== (cyc >= 1 && cyc <= 8) || done8 !== (cyc == 9)) begin
                failures++;
                $display("FAIL %s ctl cyc=%0d stall=%b busy=%b done=%b", name, cyc, stall8, busy8, done8);
            end
            if (cyc == 9) begin
                checks++;
                if ({hi8, lo8} !== exp_p) begin
                    failures++;
                    $display("FAIL %s product got=%h exp=%h", name, {hi8, lo8}, exp_p);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        $display("mul8 %s a=%h b=%h s=%b -> %h%h", name, a, b, s, hi8, lo8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; signed_op = 0; op_a = 0; op_b = 0; flush = 0;
        start8 = 0; signed8 = 0; a8 = 0; b8 = 0; flush8 = 0;
        @(negedge clk);
        checks++;
        if ({stall, busy, done, result_hi, result_lo} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b/%b/%b %h%h exp=0", stall, busy, done, result_hi, result_lo);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall, busy, done, stall8, busy8, done8} !== 6'b0) begin
            failures++;
            $display("FAIL reset_release ctl=%b exp=0", {stall, busy, done, stall8, busy8, done8});
        end
        $display("reset done");
    endtask

    task automatic test_unsigned_max();
        do_mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
        checks++;
        if (result_hi !== 32'hFFFF_FFFE || result_lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL umax_hold got=%h%h exp=fffffffe00000001", result_hi, result_lo);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen_done;
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; op_a = 7; op_b = 9;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
        end
        #2;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, busy, done, result_hi, result_lo} !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%b/%b/%b %h%h exp=0", stall, busy, done, result_hi, result_lo);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done || busy || stall) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("FAIL reset_mid_idle activity=1 exp=0");
        end
        $display("reset mid-busy done");
    endtask

    task automatic test_signed();
        do_mul32(32'hFFFF_FFFD, 32'd5, 1'b1, "s_m3x5");
        checks++;
        if ({result_hi, result_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            failures++;
            $display("FAIL s_m3x5_const got=%h%h exp=fffffffffffffff1", result_hi, result_lo);
        end
        do_mul32(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minxmin");
        checks++;
        if ({result_hi, result_lo} !== 64'h4000_0000_0000_0000) begin
            failures++;
            $display("FAIL s_minxmin_const got=%h%h exp=4000000000000000", result_hi, result_lo);
        end
        do_mul32(32'hFFFF_FFF9, 32'd0, 1'b1, "s_m7x0");
        checks++;
        if ({result_hi, result_lo} !== 64'h0) begin
            failures++;
            $display("FAIL s_m7x0_const got=%h%h exp=0", result_hi, result_lo);
        end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; op_a = 12; op_b = 12;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle stall=%b busy=%b done=%b exp=0/1/0", stall, busy, done);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle stall=%b busy=%b done=%b exp=0/0/0", stall, busy, done);
        end
        do_mul32(32'd6, 32'd7, 1'b0, "after_flush");
        checks++;
        if (result_lo !== 32'd42) begin
            failures++;
            $display("FAIL after_flush_42 got=%0d exp=42", result_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_stall;
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; op_a = 2; op_b = 3;
        for (int cyc = 0; cyc <= 67; cyc++) begin
            @(negedge clk);
            exp_stall = (cyc <= 32) || (cyc >= 34 && cyc <= 66);
            checks++;
            if (stall !== exp_stall || done !== (cyc == 33 || cyc == 67)) begin
                failures++;
                $display("FAIL b2b_ctl cyc=%0d stall=%b done=%b", cyc, stall, done);
            end
            if (cyc == 33 || cyc == 67) begin
                checks++;
                if (result_lo !== ((cyc == 33) ? 32'd6 : 32'd20) || result_hi !== 32'd0) begin
                    failures++;
                    $display("FAIL b2b_result cyc=%0d got=%h%h", cyc, result_hi, result_lo);
                end
            end
            @(posedge clk); #1;
            if (cyc == 33) begin
                op_a = 4; op_b = 5;
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_relaunch stall=%b busy=%b exp=0/0", stall, busy);
        end
        $display("back-to-back done 6,20");
    endtask

    task automatic test_random();
        logic [31:0] edge_vals [4];
        logic [31:0] a, b;
        edge_vals[0] = 32'h0; edge_vals[1] = 32'h8000_0000;
        edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            do_mul32(a, b, 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    task automatic test_width8();
        do_mul8(8'hFF, 8'h02, 1'b0, "w8_ff_x2");
        checks++;
        if ({hi8, lo8} !== 16'h01FE) begin
            failures++;
            $display("FAIL w8_const got=%h exp=01fe", {hi8, lo8});
        end
        do_mul8(8'h80, 8'h80, 1'b1, "w8_minxmin");
        do_mul8(8'h80, 8'hFF, 1'b0, "w8_carry");
        for (int i = 0; i < 8; i++) begin
            do_mul8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "w8_rand");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_reset_mid_busy();
        test_signed();
        test_flush();
        test_back_to_back();
        test_random();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
